// File: rtl/mixer_pipelined_pkg.sv
// Shared constants and state type for the pipelined vocoder channel mixer.
package mixer_pipelined_pkg;
  localparam int N_FILTERS     = 16;
  localparam int AUDIO_WIDTH   = 24;
  localparam int CHANNEL_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} mixer_state_t;
endpackage

// File: rtl/mixer_pipelined_sat_clamp.sv
// Combinational narrowing of a wide signed value: clamp or wrap, plus range overflow flag.
module sat_clamp #(
  parameter int IN_W  = 67,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  value,
  input  logic                    sat_en,
  output logic signed [OUT_W-1:0] result,
  output logic                    overflow
);
  // In range exactly when every bit from the output sign bit upwards agrees.
  logic [IN_W-OUT_W:0] upper;
  assign upper    = value[IN_W-1:OUT_W-1];
  assign overflow = !((&upper) || !(|upper));

  always_comb begin
    result = value[OUT_W-1:0];
    if (sat_en && overflow)
      result = value[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/mixer_pipelined.sv
// Multiply-shift-accumulate mixer: snapshots a frame, issues one channel per cycle
// through a 3-stage pipeline and emits one clamped or wrapped audio sample.
module mixer_pipelined
  import mixer_pipelined_pkg::*;
#(
  parameter int N_CHANNELS = N_FILTERS,
  parameter int IN_WIDTH   = CHANNEL_WIDTH,
  parameter int OUT_WIDTH  = AUDIO_WIDTH,
  parameter int ACC_WIDTH  = 2*IN_WIDTH + $clog2(N_CHANNELS) + 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [4:0]                  shift_in,
  input  logic                        sat_en_in,
  input  logic [N_CHANNELS-1:0]       chan_en_in,
  input  logic signed [IN_WIDTH-1:0]  carrier_in  [N_CHANNELS],
  input  logic signed [IN_WIDTH-1:0]  envelope_in [N_CHANNELS],
  output logic signed [OUT_WIDTH-1:0] mixed_out,
  output logic                        valid_out,
  output logic                        overflow_out
);
  localparam int PW = 2*IN_WIDTH;
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  mixer_state_t state_reg, state_next;

  logic signed [IN_WIDTH-1:0]  carrier_reg  [N_CHANNELS];
  logic signed [IN_WIDTH-1:0]  envelope_reg [N_CHANNELS];
  logic [N_CHANNELS-1:0]       chan_en_reg;
  logic [4:0]                  shift_reg;
  logic                        sat_en_reg;
  logic [CW-1:0]               idx_reg;

  logic signed [PW-1:0]        s1_prod_reg, s2_prod_reg;
  logic                        s1_vld_reg, s1_last_reg, s2_vld_reg, s2_last_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic                        acc_last_reg;

  logic                        accept, issue, last_issue;
  logic signed [OUT_WIDTH-1:0] clamp_result;
  logic                        clamp_overflow;

  assign accept     = valid_in && ready_out;
  assign issue      = (state_reg == RUN);
  assign last_issue = issue && (idx_reg == CW'(N_CHANNELS-1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept)       state_next = RUN;
      RUN:     if (last_issue)   state_next = DRAIN;
      DRAIN:   if (acc_last_reg) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state_reg == IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        carrier_reg[i]  <= '0;
        envelope_reg[i] <= '0;
      end
      chan_en_reg  <= '0;
      shift_reg    <= '0;
      sat_en_reg   <= 1'b0;
      idx_reg      <= '0;
      s1_prod_reg  <= '0;
      s1_vld_reg   <= 1'b0;
      s1_last_reg  <= 1'b0;
      s2_prod_reg  <= '0;
      s2_vld_reg   <= 1'b0;
      s2_last_reg  <= 1'b0;
      acc_reg      <= '0;
      acc_last_reg <= 1'b0;
      mixed_out    <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (accept) begin
        carrier_reg  <= carrier_in;
        envelope_reg <= envelope_in;
        chan_en_reg  <= chan_en_in;
        shift_reg    <= shift_in;
        sat_en_reg   <= sat_en_in;
        idx_reg      <= '0;
      end else if (issue && !last_issue) begin
        idx_reg <= idx_reg + 1'b1;
      end

      // S1: disabled channels still consume a slot but contribute zero.
      s1_vld_reg  <= issue;
      s1_last_reg <= last_issue;
      s1_prod_reg <= (issue && chan_en_reg[idx_reg])
                     ? PW'(carrier_reg[idx_reg]) * PW'(envelope_reg[idx_reg]) : '0;

      s2_vld_reg  <= s1_vld_reg;
      s2_last_reg <= s1_last_reg;
      s2_prod_reg <= s1_prod_reg >>> {shift_reg, 1'b0};

      if (accept)
        acc_reg <= '0;
      else if (s2_vld_reg)
        acc_reg <= acc_reg + {{(ACC_WIDTH-PW){s2_prod_reg[PW-1]}}, s2_prod_reg};
      acc_last_reg <= s2_vld_reg && s2_last_reg;

      valid_out <= acc_last_reg;
      if (acc_last_reg) begin
        mixed_out    <= clamp_result;
        overflow_out <= clamp_overflow;
      end
    end
  end

  sat_clamp #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (OUT_WIDTH)
  ) u_sat_clamp (
    .value    (acc_reg),
    .sat_en   (sat_en_reg),
    .result   (clamp_result),
    .overflow (clamp_overflow)
  );
endmodule

// File: tb/tb_mixer_pipelined.sv
// Scoreboard bench for mixer_pipelined: directed and random frames against a sum-of-products model.
module tb_mixer_pipelined;
  localparam int N  = 4;
  localparam int IW = 32;
  localparam int OW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out;
  logic [4:0] shift_in = '0;
  logic sat_en_in = 1'b0;
  logic [N-1:0] chan_en_in = '0;
  logic signed [IW-1:0] carrier_in [N];
  logic signed [IW-1:0] envelope_in [N];
  logic signed [OW-1:0] mixed_out;
  logic valid_out;
  logic overflow_out;

  always #5 clk = ~clk;

  mixer_pipelined #(.N_CHANNELS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .shift_in(shift_in), .sat_en_in(sat_en_in), .chan_en_in(chan_en_in),
    .carrier_in(carrier_in), .envelope_in(envelope_in),
    .mixed_out(mixed_out), .valid_out(valid_out), .overflow_out(overflow_out)
  );

  typedef struct {
    int c[N];
    int e[N];
    logic [N-1:0] en;
    logic [4:0] sh;
    logic sat;
  } frame_t;

  typedef struct {
    logic signed [OW-1:0] m;
    logic o;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sum of enabled products, each floor-divided by 4^shift, then range-checked.
  function automatic exp_t model(input frame_t f);
    exp_t r;
    logic signed [127:0] sum, t;
    longint p;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (f.en[i]) begin
        p = longint'(f.c[i]) * longint'(f.e[i]);
        t = p >>> (2 * f.sh);
        sum = sum + t;
      end
    end
    r.o = (sum > 128'sd8388607) || (sum < -128'sd8388608);
    if (r.o && f.sat) r.m = (sum < 0) ? 24'sh800000 : 24'sh7FFFFF;
    else              r.m = sum[OW-1:0];
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic frame_t mk(input int c0, c1, c2, c3, e0, e1, e2, e3,
                                input logic [N-1:0] en, input logic [4:0] sh, input logic sat);
    frame_t f;
    f.c[0] = c0; f.c[1] = c1; f.c[2] = c2; f.c[3] = c3;
    f.e[0] = e0; f.e[1] = e1; f.e[2] = e2; f.e[3] = e3;
    f.en = en; f.sh = sh; f.sat = sat;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       begin f.c[i] = int'($urandom_range(0, 2000)) - 1000;
                       f.e[i] = int'($urandom_range(0, 2000)) - 1000; end
        1:       begin f.c[i] = int'($urandom_range(0, 65535)) - 32768;
                       f.e[i] = int'($urandom_range(0, 65535)) - 32768; end
        default: begin f.c[i] = int'($urandom()); f.e[i] = int'($urandom()); end
      endcase
    end
    f.en  = N'($urandom());
    f.sh  = (mode == 2) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
    f.sat = 1'($urandom());
    return f;
  endfunction

  task automatic drive(input frame_t f);
    for (int i = 0; i < N; i++) begin
      carrier_in[i]  = f.c[i];
      envelope_in[i] = f.e[i];
    end
    chan_en_in = f.en;
    shift_in   = f.sh;
    sat_en_in  = f.sat;
  endtask

  // Offer a frame, record the expected result at the accepting edge, then scramble inputs.
  task automatic offer(input frame_t f, input bit hold);
    exp_t x;
    int n;
    @(negedge clk);
    drive(f);
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: ready_out=%0b after %0d cycles, required 1", ready_out, n);
    end
    x = model(f);
    x.acc_cyc = cyc + 1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    drive(rand_frame());
    if (!hold) valid_in = 1'b0;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          x = sb.pop_front();
          $display("frame out: mixed=%0d ovf=%0b latency=%0d (expect %0d/%0b)",
                   mixed_out, overflow_out, cyc - x.acc_cyc, x.m, x.o);
          chk("mixed_out", mixed_out, x.m);
          chk("overflow_out", longint'(overflow_out), longint'(x.o));
          chk("latency", cyc - x.acc_cyc, N + 3);
          chk("ready_in_valid_cycle", longint'(ready_out), 1);
        end
      end
    end
  end

  initial begin
    frame_t f1;
    int n;
    for (int i = 0; i < N; i++) begin
      carrier_in[i]  = '0;
      envelope_in[i] = '0;
    end
    f1 = mk(1, 2, 3, 4, 10, 10, 10, 10, 4'hF, 5'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_mixed_out", mixed_out, 0);
    chk("reset_valid_out", longint'(valid_out), 0);
    chk("reset_overflow_out", longint'(overflow_out), 0);
    chk("reset_ready_out", longint'(ready_out), 1);
    rst_n = 1'b1;

    offer(f1, 1'b0);
    offer(mk(-256, 0, 0, 0, 16, 16, 16, 16, 4'hF, 5'd1, 1'b0), 1'b0);
    offer(mk(-5, 0, 0, 0, 1, 1, 1, 1, 4'hF, 5'd1, 1'b0), 1'b0);
    offer(mk(1, 2, 3, 4, 10, 10, 10, 10, 4'b0101, 5'd0, 1'b0), 1'b0);
    offer(mk(8388613, 0, 0, 0, 1, 1, 1, 1, 4'hF, 5'd0, 1'b1), 1'b0);
    offer(mk(8388613, 0, 0, 0, 1, 1, 1, 1, 4'hF, 5'd0, 1'b0), 1'b0);

    // A valid_in pulse while busy must be dropped, not queued.
    offer(f1, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_ready_out", longint'(ready_out), 0);
    drive(rand_frame());
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;

    for (int k = 0; k < 6; k++) offer(rand_frame(), 1'b1);
    valid_in = 1'b0;

    for (int k = 0; k < 30; k++) offer(rand_frame(), 1'b0);

    // Mid-frame reset three edges after accept discards the frame.
    offer(mk(7, 7, 7, 7, 9, 9, 9, 9, 4'hF, 5'd0, 1'b0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_mixed_out", mixed_out, 0);
    chk("midreset_valid_out", longint'(valid_out), 0);
    chk("midreset_overflow_out", longint'(overflow_out), 0);
    chk("midreset_ready_out", longint'(ready_out), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    offer(f1, 1'b0);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mixer_pipelined.md
# mixer_pipelined

Parametrised successor to the vocoder channel mixer. Multiplies each carrier channel by its envelope channel, arithmetically right-shifts each product by a runtime amount, and accumulates all enabled channels into one audio sample. It sits between the filter bank/envelope followers and the audio output path. It adds an input handshake, input snapshotting, a per-channel enable mask, a one-channel-per-cycle pipeline and a selectable saturate/wrap output.

## Interface
- N_CHANNELS, default N_FILTERS (constants package): number of channels; must be ≥1.
- IN_WIDTH, default 32: signed width of carrier and envelope samples.
- OUT_WIDTH, default 24: signed width of the mixed output.
- ACC_WIDTH, default 2*IN_WIDTH+$clog2(N_CHANNELS)+1: accumulator width. This width can never overflow internally.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- valid_in  in  1  frame offered; accepted when valid_in && ready_out.
- ready_out  out  1  high only in IDLE.
- shift_in  in  5  shift code; the effective right shift is 2*shift_in (0..62).
- sat_en_in  in  1  1 = clamp the output, 0 = wrap (keep the low OUT_WIDTH bits).
- chan_en_in  in  N_CHANNELS  per-channel enable mask.
- carrier_in  in  N_CHANNELS×IN_WIDTH  signed carrier samples, unpacked array.
- envelope_in  in  N_CHANNELS×IN_WIDTH  signed envelope samples, unpacked array.
- mixed_out  out  OUT_WIDTH  signed mixed sample; held until the next frame completes.
- valid_out  out  1  one-cycle pulse when mixed_out updates.
- overflow_out  out  1  the last frame's sum fell outside the OUT_WIDTH range; updates with valid_out.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on accept.
  - RUN -> DRAIN after channel N_CHANNELS-1 is issued.
  - DRAIN -> IDLE when the final result is registered.
- On accept, the block snapshots these inputs into internal registers: carrier_in, envelope_in, chan_en_in, shift_in, sat_en_in. Inputs may change freely afterwards.
- Pipeline, one channel issued per cycle in RUN (index 0..N_CHANNELS-1), each stage registered:
  - S1 multiply: full 2*IN_WIDTH signed product. The product is forced to 0 if the channel is disabled.
  - S2 shift: arithmetic right shift by {shift,1'b0}.
  - S3 accumulate: sign-extend to ACC_WIDTH and add. The accumulator clears on accept.
- Output stage, after the last accumulate:
  - overflow = sum > 2^(OUT_WIDTH-1)-1 or sum < -2^(OUT_WIDTH-1).
  - If sat_en, clamp to the range limit; otherwise take sum[OUT_WIDTH-1:0].
  - overflow_out reflects overflow in both modes.
- Disabled channels still occupy their issue slot, so latency is fixed.
- valid_in while not ready_out is ignored (not queued).
- Reset, asynchronous and effective mid-frame: the in-flight frame is discarded, state goes to IDLE, and outputs take their reset values.
- Reset values: mixed_out=0, valid_out=0, overflow_out=0, ready_out=1. The accumulator and pipeline registers are cleared.

## Timing
- Latency: accept at clock edge E0; valid_out is high in the cycle following edge E(N_CHANNELS+3).
- Throughput: one frame per N_CHANNELS+3 cycles.
- ready_out is low from the cycle after E0 through DRAIN. It is high again in the same cycle that valid_out pulses, so a new frame may be accepted in the valid_out cycle (back-to-back).
- N_CHANNELS=1: RUN lasts one cycle; latency is 4.
- All outputs are registered; no combinational input-to-output path except ready_out (decoded from state).

## Structure
- Constants package holds N_FILTERS, AUDIO_WIDTH (24) and CHANNEL_WIDTH (32), which serve as the defaults here.
- The mixer_state_t enum (IDLE, RUN, DRAIN) goes in the same package for testbench visibility.
- One sub-module: sat_clamp (parameters IN_W, OUT_W; inputs value and sat_en; outputs result and overflow). It is combinational and instantiated at the output stage only.
- Target size: about 150–250 lines including sat_clamp.

## Test plan
- Reset then single frame. N_CHANNELS=4, carrier={1,2,3,4}, envelope={10,10,10,10}, shift=0, all enabled -> mixed_out=100, valid_out exactly at accept+7 cycles, overflow_out=0.
- Shift and sign. carrier ch0=-256, envelope ch0=16, other channels 0, shift=1 (>>2) -> mixed_out=-1024. Also an odd negative product: -5*1 with shift=1 -> -2 (arithmetic floor).
- Mask. As the first scenario with chan_en=4'b0101 -> mixed_out=40; latency unchanged.
- Saturation. Products summing to 2^23+5: sat_en=1 -> 8388607 with overflow_out=1; sat_en=0 -> wrapped low 24 bits (-8388603), overflow_out=1.
- Handshake and snapshot:
  - Change inputs the cycle after accept: the result still uses the snapshot values.
  - valid_in held high throughout: frames are accepted in each valid_out cycle, giving a back-to-back period of N+3.
  - Pulsing valid_in during RUN: the pulse is ignored.
- Mid-frame reset. Assert rst_n_in low at accept+3 -> all outputs 0 immediately, ready_out=1, no valid_out. The next frame after release produces the correct result.
